// File: rtl/irq_controller_if.sv
// CPU-facing bundle of the interrupt controller: source lines,
// ack handshake, register port and the irq request.
interface irq_controller_if #(
    parameter int NUM_SRC = 8
);
    logic [NUM_SRC-1:0] src;
    logic               irq_ack;
    logic [1:0]         reg_addr;
    logic               reg_wr;
    logic [15:0]        reg_wdata;
    logic [15:0]        reg_rdata;
    logic               irq;

    modport master (
        output src, irq_ack, reg_addr, reg_wr, reg_wdata,
        input  reg_rdata, irq
    );

    modport slave (
        input  src, irq_ack, reg_addr, reg_wr, reg_wdata,
        output reg_rdata, irq
    );
endinterface

// File: rtl/irq_controller.sv
// Edge-capturing, fixed-priority interrupt controller with an
// ack/EOI handshake allowing one interrupt in service at a time.
module irq_controller #(
    parameter int NUM_SRC = 8
) (
    input logic              clk,
    input logic              rst,
    irq_controller_if.slave  bus
);
    localparam logic [1:0] A_MASK  = 2'd0;
    localparam logic [1:0] A_PEND  = 2'd1;
    localparam logic [1:0] A_CAUSE = 2'd2;
    localparam logic [1:0] A_EOI   = 2'd3;

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t             state, state_n;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending, pending_n;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] act, rise, low_bit;
    logic [3:0]         cause_id, low_id;
    logic               any_act, ack_take, irq_q;
    logic               eoi_wr, mask_wr, pend_wr;

    assign rise    = bus.src & ~src_q;
    assign act     = pending & mask;
    assign any_act = |act;
    assign low_bit = act & (~act + NUM_SRC'(1));
    assign eoi_wr  = bus.reg_wr && (bus.reg_addr == A_EOI);
    assign mask_wr = bus.reg_wr && (bus.reg_addr == A_MASK);
    assign pend_wr = bus.reg_wr && (bus.reg_addr == A_PEND);
    assign bus.irq = irq_q;

    always_comb begin
        low_id = 4'hF;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) low_id = 4'(i);
        end
    end

    // An EOI in the same cycle as an ack always wins over the ack.
    always_comb begin
        state_n  = state;
        ack_take = 1'b0;
        unique case (state)
            IDLE: begin
                if (!eoi_wr && bus.irq_ack && any_act) begin
                    state_n  = SERVICE;
                    ack_take = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi_wr) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Clears are applied first so a fresh rise on the same bit survives.
    always_comb begin
        pending_n = pending;
        if (ack_take) pending_n = pending_n & ~low_bit;
        if (pend_wr)  pending_n = pending_n & ~bus.reg_wdata[NUM_SRC-1:0];
        pending_n = pending_n | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            pending  <= '0;
            mask     <= '0;
            cause_id <= 4'hF;
            irq_q    <= 1'b0;
        end else begin
            src_q   <= bus.src;
            pending <= pending_n;
            if (mask_wr)  mask     <= bus.reg_wdata[NUM_SRC-1:0];
            if (ack_take) cause_id <= low_id;
            irq_q <= (state == IDLE) && any_act && !bus.irq_ack;
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        unique case (bus.reg_addr)
            A_MASK:  bus.reg_rdata[NUM_SRC-1:0] = mask;
            A_PEND:  bus.reg_rdata[NUM_SRC-1:0] = pending;
            A_CAUSE: bus.reg_rdata = {state == SERVICE, 11'b0, cause_id};
            A_EOI:   bus.reg_rdata = '0;
            default: bus.reg_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_irq_controller.sv
// Directed vector table plus hand-written collision and
// asynchronous-reset sequences for irq_controller.
module tb_irq_controller;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    irq_controller_if #(.NUM_SRC(N)) bus ();

    irq_controller #(.NUM_SRC(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        logic        ack;
        logic        wr;
        logic [1:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  raddr;
        logic        exp_irq;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt[26];

    task automatic cyc(input logic [7:0] s, input logic a,
                       input logic w, input logic [1:0] ad,
                       input logic [15:0] d);
        @(negedge clk);
        bus.src       = s;
        bus.irq_ack   = a;
        bus.reg_wr    = w;
        bus.reg_addr  = ad;
        bus.reg_wdata = d;
        @(posedge clk);
        #1;
        bus.irq_ack = 1'b0;
        bus.reg_wr  = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [1:0] a,
                       input logic [15:0] exp);
        bus.reg_addr = a;
        #1;
        tests++;
        if (bus.reg_rdata !== exp) begin
            fails++;
            $display("FAIL %s: rdata=%h expected %h", nm, bus.reg_rdata, exp);
        end
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        #1;
        tests++;
        if (bus.irq !== exp) begin
            fails++;
            $display("FAIL %s: irq=%b expected %b", nm, bus.irq, exp);
        end
    endtask

    initial begin
        // src ack wr waddr wdata raddr irq rdata
        vt[0]  = '{8'h00, 0, 1, 2'd0, 16'h00FF, 2'd0, 0, 16'h00FF};
        vt[1]  = '{8'h08, 0, 0, 2'd0, 16'h0000, 2'd1, 0, 16'h0008};
        vt[2]  = '{8'h00, 0, 0, 2'd0, 16'h0000, 2'd1, 1, 16'h0008};
        vt[3]  = '{8'h00, 1, 0, 2'd0, 16'h0000, 2'd2, 0, 16'h8003};
        vt[4]  = '{8'h00, 0, 0, 2'd0, 16'h0000, 2'd1, 0, 16'h0000};
        vt[5]  = '{8'h00, 0, 1, 2'd3, 16'h1234, 2'd2, 0, 16'h0003};
        vt[6]  = '{8'h24, 0, 0, 2'd0, 16'h0000, 2'd1, 0, 16'h0024};
        vt[7]  = '{8'h24, 0, 0, 2'd0, 16'h0000, 2'd1, 1, 16'h0024};
        vt[8]  = '{8'h24, 1, 0, 2'd0, 16'h0000, 2'd2, 0, 16'h8002};
        vt[9]  = '{8'h24, 0, 0, 2'd0, 16'h0000, 2'd1, 0, 16'h0020};
        vt[10] = '{8'h24, 0, 1, 2'd3, 16'h0000, 2'd2, 0, 16'h0002};
        vt[11] = '{8'h24, 0, 0, 2'd0, 16'h0000, 2'd2, 1, 16'h0002};
        vt[12] = '{8'h24, 1, 0, 2'd0, 16'h0000, 2'd2, 0, 16'h8005};
        vt[13] = '{8'h00, 0, 0, 2'd0, 16'h0000, 2'd1, 0, 16'h0000};
        vt[14] = '{8'h00, 0, 1, 2'd3, 16'h0000, 2'd2, 0, 16'h0005};
        vt[15] = '{8'h00, 1, 0, 2'd0, 16'h0000, 2'd2, 0, 16'h0005};
        vt[16] = '{8'h00, 0, 1, 2'd0, 16'h0001, 2'd0, 0, 16'h0001};
        vt[17] = '{8'h10, 0, 0, 2'd0, 16'h0000, 2'd1, 0, 16'h0010};
        vt[18] = '{8'h00, 0, 0, 2'd0, 16'h0000, 2'd1, 0, 16'h0010};
        vt[19] = '{8'h00, 0, 1, 2'd0, 16'h0010, 2'd0, 0, 16'h0010};
        vt[20] = '{8'h00, 0, 0, 2'd0, 16'h0000, 2'd2, 1, 16'h0005};
        vt[21] = '{8'h00, 1, 0, 2'd0, 16'h0000, 2'd2, 0, 16'h8004};
        vt[22] = '{8'h00, 1, 0, 2'd0, 16'h0000, 2'd2, 0, 16'h8004};
        vt[23] = '{8'h00, 0, 1, 2'd0, 16'hFFFF, 2'd0, 0, 16'h00FF};
        vt[24] = '{8'h00, 0, 1, 2'd3, 16'h0000, 2'd2, 0, 16'h0004};
        vt[25] = '{8'h00, 0, 1, 2'd1, 16'h00FF, 2'd3, 0, 16'h0000};

        bus.src       = '0;
        bus.irq_ack   = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_irq("rst_irq", 1'b0);
        chk("rst_cause", 2'd2, 16'h000F);
        chk("rst_pend", 2'd1, 16'h0000);
        chk("rst_mask", 2'd0, 16'h0000);

        for (int i = 0; i < 26; i++) begin
            cyc(vt[i].src, vt[i].ack, vt[i].wr, vt[i].waddr, vt[i].wdata);
            chk_irq($sformatf("vec%0d_irq", i), vt[i].exp_irq);
            chk($sformatf("vec%0d_rd", i), vt[i].raddr, vt[i].exp_rd);
        end

        // rise and W1C on the same bit
        cyc(8'h02, 0, 0, 2'd0, 16'h0000);
        cyc(8'h00, 0, 0, 2'd0, 16'h0000);
        cyc(8'h02, 0, 1, 2'd1, 16'h0002);
        chk("w1c_vs_rise", 2'd1, 16'h0002);
        cyc(8'h02, 0, 1, 2'd1, 16'h0002);
        chk("w1c_plain", 2'd1, 16'h0000);
        cyc(8'h00, 0, 0, 2'd0, 16'h0000);

        // rise and ack on the same bit
        cyc(8'h01, 0, 0, 2'd0, 16'h0000);
        cyc(8'h00, 0, 0, 2'd0, 16'h0000);
        chk_irq("ackcol_irq", 1'b1);
        cyc(8'h01, 1, 0, 2'd0, 16'h0000);
        chk_irq("ackcol_drop", 1'b0);
        chk("ackcol_cause", 2'd2, 16'h8000);
        chk("ackcol_pend", 2'd1, 16'h0001);
        cyc(8'h00, 0, 1, 2'd3, 16'h0000);
        chk_irq("eoi_lat0", 1'b0);
        cyc(8'h00, 0, 0, 2'd0, 16'h0000);
        chk_irq("eoi_reassert", 1'b1);
        chk("eoi_cause", 2'd2, 16'h0000);
        cyc(8'h00, 1, 0, 2'd0, 16'h0000);
        chk("reack_cause", 2'd2, 16'h8000);
        chk("reack_pend", 2'd1, 16'h0000);

        // EOI and ack together: EOI wins
        cyc(8'h40, 0, 0, 2'd0, 16'h0000);
        cyc(8'h40, 1, 1, 2'd3, 16'h0000);
        chk("eoiack_cause", 2'd2, 16'h0000);
        chk("eoiack_pend", 2'd1, 16'h0040);
        cyc(8'h00, 0, 0, 2'd0, 16'h0000);
        chk_irq("eoiack_irq", 1'b1);

        // mask write and ack together: ack sees old mask
        cyc(8'h00, 1, 1, 2'd0, 16'h0000);
        chk("maskack_cause", 2'd2, 16'h8006);
        chk("maskack_mask", 2'd0, 16'h0000);

        // asynchronous reset in the middle of service
        cyc(8'h00, 0, 1, 2'd3, 16'h0000);
        cyc(8'h00, 0, 1, 2'd0, 16'h00FF);
        cyc(8'h01, 0, 0, 2'd0, 16'h0000);
        cyc(8'h00, 0, 0, 2'd0, 16'h0000);
        cyc(8'h00, 1, 0, 2'd0, 16'h0000);
        cyc(8'h05, 0, 0, 2'd0, 16'h0000);
        chk("pre_rst_pend", 2'd1, 16'h0005);
        chk("pre_rst_cause", 2'd2, 16'h8000);
        #1 rst = 1'b1;
        chk_irq("arst_irq", 1'b0);
        chk("arst_cause", 2'd2, 16'h000F);
        chk("arst_pend", 2'd1, 16'h0000);
        chk("arst_mask", 2'd0, 16'h0000);
        bus.src = '0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
